// File: rtl/wr_port_arbiter.sv
// wr_port_arbiter: round-robin arbiter sharing the register bank write port among NREQ requesters.
// Define WR_ARB_LOCK_EN to add a LOCK input and a LOCKED state for back-to-back burst writes.
module wr_port_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 STALL,
  input  logic [NREQ-1:0]      REQ,
  input  logic [NREQ*AW-1:0]   REQ_ADDR,
  input  logic [NREQ*DW-1:0]   REQ_DATA,
`ifdef WR_ARB_LOCK_EN
  input  logic [NREQ-1:0]      LOCK,
`endif
  output logic [NREQ-1:0]      GNT,
  output logic                 WE,
  output logic [AW-1:0]        WADDR,
  output logic [DW-1:0]        WDATA,
  output logic                 BUSY
);
  localparam int PW = $clog2(NREQ);
  localparam logic [PW:0] NR = NREQ[PW:0];
  localparam logic [PW-1:0] LAST = PW'(NREQ - 1);
`ifdef WR_ARB_LOCK_EN
  typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;
`else
  typedef enum logic {IDLE, GRANT} state_t;
`endif
  state_t state, state_nx;
  logic [PW-1:0] ptr, ptr_nx, win, off, sel;
  logic [PW:0] sum;
  logic found, hold;
  logic [NREQ-1:0] elig, rot, gnt_nx;
  logic [AW-1:0] waddr_nx, waddr_sel;
  logic [DW-1:0] wdata_nx, wdata_sel;
  // The requester granted last cycle is masked so a late REQ drop never writes twice
  assign elig = REQ & ~GNT;
  assign BUSY = |elig;
  assign rot = NREQ'({elig, elig} >> ptr);
  always_comb begin
    found = 1'b0;
    off = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (rot[k]) begin
        found = 1'b1;
        off = k[PW-1:0];
      end
    sum = {1'b0, ptr} + {1'b0, off};
    win = PW'(sum >= NR ? sum - NR : sum);
  end
`ifdef WR_ARB_LOCK_EN
  // PTR already points past the lock holder and stays frozen while locked
  logic [PW-1:0] holder;
  assign holder = ptr == '0 ? LAST : ptr - 1'b1;
  assign hold = state == LOCKED && REQ[holder] && LOCK[holder];
  assign sel = hold ? holder : win;
  assign WE = state == GRANT || (state == LOCKED && |GNT);
`else
  assign hold = 1'b0;
  assign sel = win;
  assign WE = state == GRANT;
`endif
  always_comb begin
    waddr_sel = '0;
    wdata_sel = '0;
    for (int k = 0; k < NREQ; k++)
      if (sel == k[PW-1:0]) begin
        waddr_sel = REQ_ADDR[k*AW +: AW];
        wdata_sel = REQ_DATA[k*DW +: DW];
      end
  end
  always_comb begin
    state_nx = state;
    ptr_nx = ptr;
    gnt_nx = '0;
    waddr_nx = WADDR;
    wdata_nx = WDATA;
    if (STALL) begin
`ifdef WR_ARB_LOCK_EN
      state_nx = state == LOCKED ? LOCKED : IDLE;
`else
      state_nx = IDLE;
`endif
    end else if (hold || found) begin
      gnt_nx = NREQ'(1) << sel;
      waddr_nx = waddr_sel;
      wdata_nx = wdata_sel;
      if (!hold) ptr_nx = win == LAST ? '0 : win + 1'b1;
`ifdef WR_ARB_LOCK_EN
      state_nx = (hold || LOCK[win]) ? LOCKED : GRANT;
`else
      state_nx = GRANT;
`endif
    end else begin
      state_nx = IDLE;
    end
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      ptr <= '0;
      GNT <= '0;
      WADDR <= '0;
      WDATA <= '0;
    end else begin
      state <= state_nx;
      ptr <= ptr_nx;
      GNT <= gnt_nx;
      WADDR <= waddr_nx;
      WDATA <= wdata_nx;
    end
  end
endmodule

// File: tb/tb_wr_port_arbiter.sv
// tb_wr_port_arbiter: directed and pseudo-random stimulus against a round-robin reference model.
module tb_wr_port_arbiter;
  localparam int NREQ = 4, AW = 5, DW = 32;
  logic CLK = 1'b0, RST_N = 1'b0, STALL = 1'b0;
  logic [NREQ-1:0] REQ = '0;
  logic [NREQ*AW-1:0] REQ_ADDR = '0;
  logic [NREQ*DW-1:0] REQ_DATA = '0;
`ifdef WR_ARB_LOCK_EN
  logic [NREQ-1:0] LOCK = '0;
`endif
  logic [NREQ-1:0] GNT;
  logic WE, BUSY;
  logic [AW-1:0] WADDR;
  logic [DW-1:0] WDATA;
  int checks = 0, errors = 0;
  int m_ptr, m_g;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [NREQ-1:0] eg;
  logic [NREQ-1:0] rr_exp [8] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};

  wr_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RST_N(RST_N), .STALL(STALL), .REQ(REQ), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
`ifdef WR_ARB_LOCK_EN
    .LOCK(LOCK),
`endif
    .GNT(GNT), .WE(WE), .WADDR(WADDR), .WDATA(WDATA), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    REQ_ADDR[i*AW +: AW] = a;
    REQ_DATA[i*DW +: DW] = d;
  endtask

  // Reference: integer pointer, modulo search, last grant excluded
  always @(posedge CLK or negedge RST_N) begin : model
    int w, i;
    if (!RST_N) begin
      m_ptr = 0;
      m_g = -1;
      m_addr = '0;
      m_data = '0;
    end else if (STALL) begin
      m_g = -1;
    end else begin
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        i = (m_ptr + k) % NREQ;
        if (w < 0 && REQ[i] && i != m_g) w = i;
      end
      m_g = w;
      if (w >= 0) begin
        m_ptr = (w + 1) % NREQ;
        m_addr = REQ_ADDR[w*AW +: AW];
        m_data = REQ_DATA[w*DW +: DW];
      end
    end
  end

  always @(negedge CLK) begin
    eg = (m_g < 0) ? '0 : NREQ'(1) << m_g;
    check("m_gnt", GNT, eg);
    check("m_we", WE, m_g >= 0);
    check("m_busy", BUSY, |(REQ & ~eg));
    check("m_waddr", WADDR, m_addr);
    check("m_wdata", WDATA, m_data);
  end

  initial begin
    step();
    step();
    check("rst_gnt", GNT, 0);
    check("rst_we", WE, 0);
    check("rst_waddr", WADDR, 0);
    check("rst_wdata", WDATA, 0);
    set_req(0, 5'd3, 32'h11);
    REQ = 4'b0001;
    RST_N = 1'b1;
    step();
    check("pre_rst_gnt", GNT, 4'b0001);
    check("pre_rst_we", WE, 1);
    #1 RST_N = 1'b0;
    #1;
    check("async_gnt", GNT, 0);
    check("async_we", WE, 0);
    check("async_waddr", WADDR, 0);
    step();
    RST_N = 1'b1;
    step();
    check("post_rst_gnt", GNT, 4'b0001);
    check("post_rst_waddr", WADDR, 5'd3);
    REQ = '0;
    step();
    check("post_rst_idle", GNT, 0);
    set_req(2, 5'd7, 32'hDEADBEEF);
    REQ = 4'b0100;
    step();
    check("single_gnt", GNT, 4'b0100);
    check("single_we", WE, 1);
    check("single_waddr", WADDR, 5'd7);
    check("single_wdata", WDATA, 32'hDEADBEEF);
    REQ = '0;
    step();
    check("single_done_we", WE, 0);
    check("single_hold_waddr", WADDR, 5'd7);
    set_req(0, 5'd1, 32'hA0);
    REQ = 4'b0101;
    step();
    check("wrap_gnt0", GNT, 4'b0001);
    step();
    check("wrap_gnt2", GNT, 4'b0100);
    check("wrap_waddr", WADDR, 5'd7);
    REQ = '0;
    step();
    check("wrap_idle", GNT, 0);
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(10 + i), 32'hC000_0000 + i);
    REQ = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step();
      check("rr_gnt", GNT, rr_exp[k]);
      check("rr_we", WE, 1);
    end
    REQ = '0;
    step();
    REQ = 4'b0011;
    STALL = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_gnt", GNT, 0);
      check("stall_we", WE, 0);
      check("stall_busy", BUSY, 1);
    end
    STALL = 1'b0;
    step();
    check("unstall_gnt0", GNT, 4'b0001);
    step();
    check("unstall_gnt1", GNT, 4'b0010);
    REQ = '0;
    step();
    REQ = 4'b1000;
    STALL = 1'b1;
    step();
    REQ = '0;
    STALL = 1'b0;
    step();
    check("withdraw_gnt", GNT, 0);
    check("withdraw_we", WE, 0);
    repeat (60) begin
      REQ = NREQ'($urandom);
      STALL = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NREQ; i++) set_req(i, AW'($urandom), $urandom);
      step();
    end
    REQ = '0;
    STALL = 1'b0;
    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
